hc259_byte_writer: RTL and testbench

Sequencer upstream of the LOGIC_74HC259 addressable-latch model in the TTM4 emulator. It accepts a byte over a valid/ready handshake and drives the latch's A, D, nLE and nMR pins. For each bit that must change, it applies a setup/strobe/hold sequence so the latch Q outputs end up equal to the byte. It keeps a mirror of the latch contents so that unchanged bits are skipped, and it also sequences an explicit master clear.

---
 rtl/hc259_byte_writer_if.sv | 21 ++
 rtl/hc259_byte_writer.sv | 120 ++++++++++++
 tb/tb_hc259_byte_writer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hc259_byte_writer_if.sv
// hc259_byte_writer_if: byte/clear request handshake and 74HC259 pin bundle
interface hc259_byte_writer_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       clr_req;
  logic [2:0] a;
  logic       d;
  logic       nle;
  logic       nmr;
  logic       busy;
  logic       done;
  modport master (
    output din, din_valid, clr_req,
    input  din_ready, a, d, nle, nmr, busy, done
  );
  modport slave (
    input  din, din_valid, clr_req,
    output din_ready, a, d, nle, nmr, busy, done
  );
endinterface

// File: rtl/hc259_byte_writer.sv
// hc259_byte_writer: writes a byte into a 74HC259 one changed bit at a time
// with setup/strobe/hold timing, and sequences master clears.
module hc259_byte_writer #(
  parameter int unsigned SETUP_CYC      = 1,
  parameter int unsigned STROBE_CYC     = 2,
  parameter int unsigned HOLD_CYC       = 1,
  parameter bit          SKIP_UNCHANGED = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  hc259_byte_writer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CLEAR} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, len;
  logic [7:0] mirror_q, mirror_d, pend_q, pend_d, tgt_q, tgt_d;
  logic [2:0] a_q, a_d;
  logic       d_q, d_d, nle_q, nmr_q, done_q, done_d;
  logic       mval_q, mval_d, clrp_q, clrp_d, last;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    lowest = 3'd0;
    for (int j = 7; j >= 0; j--) if (v[j]) lowest = 3'(j);
  endfunction

  assign len  = state_q == SETUP ? 4'(SETUP_CYC) : state_q == HOLD ? 4'(HOLD_CYC) : 4'(STROBE_CYC);
  assign last = cnt_q == len - 4'd1;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    mirror_d = mirror_q;
    mval_d   = mval_q;
    a_d      = a_q;
    d_d      = d_q;
    done_d   = 1'b0;
    clrp_d   = (bus.clr_req && state_q != IDLE) ? 1'b1 : clrp_q;
    unique case (state_q)
      IDLE:
        if (bus.clr_req || clrp_q) state_d = CLEAR;
        else if (bus.din_valid) begin
          tgt_d  = bus.din;
          pend_d = (SKIP_UNCHANGED && mval_q) ? bus.din ^ mirror_q : 8'hFF;
          if (pend_d == 8'h00) done_d = 1'b1;
          else begin
            state_d = SETUP;
            a_d     = lowest(pend_d);
            d_d     = bus.din[a_d];
          end
        end
      SETUP:  if (last) state_d = STROBE;
      STROBE: if (last) state_d = HOLD;
      HOLD:
        if (last) begin
          mirror_d[a_q] = tgt_q[a_q];
          pend_d[a_q]   = 1'b0;
          if (pend_d != 8'h00) begin
            state_d = SETUP;
            a_d     = lowest(pend_d);
            d_d     = tgt_q[a_d];
          end else begin
            // a clear requested mid-byte starts right away, no IDLE gap
            mval_d  = 1'b1;
            done_d  = 1'b1;
            state_d = clrp_d ? CLEAR : IDLE;
          end
        end
      CLEAR:
        if (last) begin
          mirror_d = 8'h00;
          mval_d   = 1'b1;
          clrp_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
  end

  // pins are registered from the next state so they line up with the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      mirror_q <= 8'h00;
      mval_q   <= 1'b0;
      pend_q   <= 8'h00;
      tgt_q    <= 8'h00;
      clrp_q   <= 1'b0;
      a_q      <= 3'd0;
      d_q      <= 1'b0;
      nle_q    <= 1'b1;
      nmr_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mirror_q <= mirror_d;
      mval_q   <= mval_d;
      pend_q   <= pend_d;
      tgt_q    <= tgt_d;
      clrp_q   <= clrp_d;
      a_q      <= a_d;
      d_q      <= d_d;
      nle_q    <= state_d != STROBE;
      nmr_q    <= state_d != CLEAR;
      done_q   <= done_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.d         = d_q;
  assign bus.nle       = nle_q;
  assign bus.nmr       = nmr_q;
  assign bus.done      = done_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.din_ready = state_q == IDLE && !bus.clr_req && !clrp_q;
endmodule

// File: tb/tb_hc259_byte_writer.sv
// tb_hc259_byte_writer: transaction-level pin-sequence model plus a 74HC259
// latch model, checked every cycle, with literal DONE/strobe/Q expectations.
module tb_hc259_byte_writer;
  localparam int SC = 1, ST = 2, HC = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  hc259_byte_writer_if bus();
  hc259_byte_writer #(.SETUP_CYC(SC), .STROBE_CYC(ST), .HOLD_CYC(HC), .SKIP_UNCHANGED(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic d, nle, nmr, busy, done, ready;
  } exp_t;
  exp_t       q[$];
  exp_t       e;
  int         total = 0, bad = 0, strobes = 0;
  logic [7:0] m_mirror = 8'h00, lq = 8'h00;
  bit         m_valid = 1'b0;
  logic [2:0] la = 3'd0;
  logic       ld = 1'b0, prev_nle = 1'b1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void put(input logic [2:0] a, input logic d, nle, nmr, busy, done, ready);
    q.push_back('{a, d, nle, nmr, busy, done, ready});
  endfunction

  // expected pins from cycle 1 after the accept edge onward
  function automatic void push_byte(input logic [7:0] v, input bit clr_after);
    logic [7:0] pend = m_valid ? v ^ m_mirror : 8'hFF;
    for (int i = 0; i < 8; i++) if (pend[i]) begin
      la = 3'(i);
      ld = v[i];
      repeat (SC) put(la, ld, 1, 1, 1, 0, 0);
      repeat (ST) put(la, ld, 0, 1, 1, 0, 0);
      repeat (HC) put(la, ld, 1, 1, 1, 0, 0);
      m_mirror[i] = v[i];
    end
    m_valid = 1'b1;
    if (clr_after) begin
      put(la, ld, 1, 0, 1, 1, 0);
      repeat (ST - 1) put(la, ld, 1, 0, 1, 0, 0);
      m_mirror = 8'h00;
    end
    put(la, ld, 1, 1, 0, 1, 1);
  endfunction

  function automatic void push_clear();
    repeat (ST) put(la, ld, 1, 0, 1, 0, 0);
    put(la, ld, 1, 1, 0, 1, 1);
    m_mirror = 8'h00;
    m_valid  = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (!bus.nmr && bus.nle) lq = 8'h00;
      else if (bus.nmr && !bus.nle) lq[bus.a] = bus.d;
      if (!bus.nle && prev_nle) strobes++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pins", 16'({bus.a, bus.d, bus.nle, bus.nmr, bus.busy, bus.done, bus.din_ready}), 16'(e));
      end else
        chk("idle", 16'({bus.nle, bus.nmr, bus.busy, bus.done, bus.din_ready}), 16'({4'b1100, ~bus.clr_req}));
    end
    prev_nle = bus.nle;
  end

  task automatic drain();
    for (int n = 0; n < 300 && q.size() > 0; n++) @(posedge clk);
    chk("drained", 16'(q.size()), 16'd0);
  endtask

  task automatic wait_done(input bit clr_mid, input int exp_done);
    int cyc;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (clr_mid && cyc == 6) bus.clr_req = 1'b1;
      if (clr_mid && cyc == 7) bus.clr_req = 1'b0;
      if (bus.done) break;
    end
    chk("done_cycle", 16'(cyc), 16'(exp_done));
  endtask

  task automatic send(input logic [7:0] v, input bit clr_after, input int exp_done, exp_str,
                      input logic [7:0] exp_q);
    int s0;
    @(posedge clk); #1 bus.din = v; bus.din_valid = 1'b1;
    @(posedge clk); s0 = strobes; push_byte(v, clr_after); #1 bus.din_valid = 1'b0;
    wait_done(clr_after, exp_done);
    drain();
    chk("strobes", 16'(strobes - s0), 16'(exp_str));
    chk("latch_q", 16'(lq), 16'(exp_q));
  endtask

  task automatic clear(input bit with_din, input int exp_done);
    @(posedge clk); #1 bus.clr_req = 1'b1; bus.din = 8'h80; bus.din_valid = with_din;
    @(negedge clk); chk("ready_in_clr", 16'(bus.din_ready), 16'd0);
    @(posedge clk); push_clear(); #1 bus.clr_req = 1'b0; bus.din_valid = 1'b0;
    wait_done(1'b0, exp_done);
    drain();
    chk("latch_q_clr", 16'(lq), 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din = 8'h00; bus.din_valid = 1'b0; bus.clr_req = 1'b0;
    #12 chk("reset_state", 16'({bus.a, bus.d, bus.nle, bus.nmr, bus.busy, bus.done, bus.din_ready}), 16'b1_1001);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 bus.din = 8'h3C; bus.din_valid = 1'b1;
    @(posedge clk); push_byte(8'h3C, 1'b0); #1 bus.din_valid = 1'b0;
    for (int n = 0; n < 20 && bus.nle; n++) @(negedge clk);
    chk("reached_strobe", 16'(bus.nle), 16'd0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 16'({bus.nle, bus.nmr, bus.a, bus.d, bus.busy}), 16'b110_0000);
    m_mirror = 8'h00; m_valid = 1'b0; la = 3'd0; ld = 1'b0; q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("ready_after_rst", 16'(bus.din_ready), 16'd1);
    send(8'hA5, 1'b0, 33, 8, 8'hA5);
    send(8'hA4, 1'b0, 5, 1, 8'hA4);
    send(8'hA4, 1'b0, 1, 0, 8'hA4);
    clear(1'b0, 3);
    send(8'h01, 1'b0, 5, 1, 8'h01);
    clear(1'b1, 3);
    send(8'hFF, 1'b1, 33, 8, 8'h00);
    send(8'h5A, 1'b0, 17, 4, 8'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
